uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Consumes the synchronized UART RX line from the two-stage synchronizer.
- Deframes 8N1-style serial frames using a fixed oversampling count.
- Presents each received byte on a valid/ready output register.
- Flags framing and overrun errors.
- Sits between the RX synchronizer and the RX FIFO / bus interface.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be an even number ≥ 4; elaboration $error otherwise.
- DATA_BITS, 8, data bits per frame; legal range 5–9.

Ports:
- CLK  input  1  system clock; all logic is on posedge.
- nRST  input  1  asynchronous, active-low reset.
- rx_sync  input  1  synchronized RX line; idle high.
- rx_data  output  DATA_BITS  received data, LSB = first bit on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the holding register was full.
- parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when the parity feature is compiled out.

Behaviour:
- Reset (async, nRST low):
  - state = IDLE; bit counter and cycle counter = 0.
  - rx_data = 0; rx_valid = 0; frame_err = overrun = parity_err = 0.
  - prev_rx = 1.
  - Reset mid-frame abandons the frame silently.
- prev_rx: registered copy of rx_sync. A start edge is prev_rx = 1 and rx_sync = 0, qualified only in IDLE.
- Timing reference: T0 is the cycle the start edge is seen. The cycle counter is $clog2(CLKS_PER_BIT) bits wide.
- IDLE:
  - On a start edge, go to START and load the counter for a CLKS_PER_BIT/2 wait.
  - A line held low (break, or after a framing error) never retriggers until it returns high.
- START: at T0 + CLKS_PER_BIT/2, resample rx_sync.
  - 0: go to DATA, clear the bit index.
  - 1: glitch; return to IDLE with no error.
- DATA:
  - Bit i is sampled at T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - Samples shift in LSB first.
  - After DATA_BITS samples, go to STOP (or PARITY when that feature is enabled).
- STOP: sample one CLKS_PER_BIT later, then always return to IDLE the next cycle.
  - Sample = 1: frame good; deliver the byte.
  - Sample = 0: pulse frame_err; discard the byte.
- Delivery, on the cycle after the good stop sample:
  - Holding register empty, or emptied by rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid.
  - Otherwise: keep the old byte, drop the new one, pulse overrun.
  - Simultaneous handshake and delivery is NOT an overrun.
- Latency: with defaults, rx_valid rises at T0 + 153 cycles.
- Holding register:
  - rx_valid stays high until the handshake.
  - rx_data is stable while rx_valid is high.
  - Handshake with no new delivery clears rx_valid the next cycle.
- Error pulses are exactly one cycle and mutually exclusive per frame. Priority: parity_err over frame_err over overrun.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP, sampled CLKS_PER_BIT after the last data bit.
  - Parity is even: the XOR of the data bits and the parity bit must be 0.
  - On mismatch, pulse parity_err at the stop sample and discard the byte. A stop-bit error in the same frame reports parity_err only.
  - Frame length grows by one bit; default latency becomes T0 + 169.
- Undefined: there is no PARITY state and parity_err is constant 0.

Decomposition:
- Package uart_rx_pkg:
  - Typedef rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Localparam STOP_BIT_IDLE = 1'b1.
- Sub-module uart_rx_bit_timer:
  - Loadable down-counter.
  - Emits a one-cycle sample_tick when the count expires.
  - Reloads with CLKS_PER_BIT−1 on each tick while enabled.

Test Plan:
- Send 0xA5 with defaults, rx_ready held 1 → rx_valid for one cycle at T0+153, rx_data = 0xA5, no error pulses.
- Low glitch of 3 cycles on an idle line → no state change beyond START, rx_valid stays 0, no error pulses.
- Frame 0x3C with stop bit forced 0, line then held low 40 bit-times and released → single frame_err pulse, no rx_valid, no retrigger until the line goes high; the next frame 0x11 is received correctly.
- Two back-to-back frames 0x01 then 0x02 with rx_ready = 0 → rx_data stays 0x01, one overrun pulse at the second delivery; rx_ready then raised → 0x01 handshakes and rx_valid clears.
- rx_ready pulsed in exactly the cycle the second frame (0x02) delivers → no overrun, rx_data = 0x02, rx_valid stays 1.
- nRST asserted mid-DATA of frame 0xFF, then released, then 0x5A sent → outputs at reset values during reset, only 0x5A delivered. With UART_RX_PARITY_EN: 0x07 with parity bit 0 → parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// UART receive core shared types: FSM state encoding and line constants.
// Parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic STOP_BIT_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Loadable down-counter giving one sample_tick per serial bit period.
// Reloads CLKS_PER_BIT-1 on every tick while enabled.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            load,
  input  logic                            en,
  input  logic [$clog2(CLKS_PER_BIT)-1:0] load_val,
  output logic                            sample_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign sample_tick = en && (cnt == '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1-style deframer with valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 rx_sync,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 4) begin : g_bad_clks
    $error("CLKS_PER_BIT must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("DATA_BITS must be 5..9");
  end

  rx_state_t            state;
  logic                 prev_rx;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 done_q;
  logic                 stop_q;
  logic                 par_bad;
  logic                 tick;
  logic                 start_edge;
  logic                 tmr_load;
  logic                 tmr_en;

  assign start_edge = prev_rx && !rx_sync;
  assign tmr_load   = (state == IDLE) && start_edge;
  assign tmr_en     = (state != IDLE);

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .CLK        (CLK),
    .nRST       (nRST),
    .load       (tmr_load),
    .en         (tmr_en),
    .load_val   (HALF),
    .sample_tick(tick)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_bad = ^{shreg, par_bit};
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // done_q marks the cycle after the stop sample; delivery acts on it
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      prev_rx <= 1'b1;
      idx     <= '0;
      shreg   <= '0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      prev_rx <= rx_sync;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: if (start_edge) state <= START;
        START: if (tick) begin
          if (rx_sync) begin
            state <= IDLE;
          end else begin
            state <= DATA;
            idx   <= '0;
          end
        end
        DATA: if (tick) begin
          shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick) begin
            par_bit <= rx_sync;
            state   <= STOP;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: if (tick) begin
          done_q <= 1'b1;
          stop_q <= rx_sync;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done_q) begin
        if (par_bad) begin
`ifdef UART_RX_PARITY_EN
          parity_err <= 1'b1;
`endif
        end else if (stop_q != STOP_BIT_IDLE) begin
          frame_err <= 1'b1;
        end else if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: latency, glitch, framing, overrun,
// same-cycle handshake, mid-frame reset and (with UART_RX_PARITY_EN) parity.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int PER  = 10;
  localparam int HALF = PER / 2;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 169;
`else
  localparam int LAT  = 153;
`endif

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       rx_sync = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) u_dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .rx_sync   (rx_sync),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #HALF CLK = ~CLK;

  int   total = 0;
  int   bad = 0;
  int   n_rise = 0;
  int   n_high = 0;
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   n_perr = 0;
  int   rise_data = 0;
  time  rise_t = 0;
  time  t_start = 0;
  time  tp;
  logic pv = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    tp = $time;
    #1;
    if (rx_valid) n_high++;
    if (rx_valid && !pv) begin
      n_rise++;
      rise_t    = tp;
      rise_data = int'(rx_data);
    end
    pv = rx_valid;
    if (frame_err)  n_ferr++;
    if (overrun)    n_ovr++;
    if (parity_err) n_perr++;
  end

  task automatic clr();
    n_rise = 0;
    n_high = 0;
    n_ferr = 0;
    n_ovr  = 0;
    n_perr = 0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (i == 0) t_start = $time;
      rx_sync = bits[i];
      repeat (CPB - 1) @(negedge CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stp,
                            input logic flip);
`ifdef UART_RX_PARITY_EN
    send_bits(16'({stp, (^d) ^ flip, d, 1'b0}), 11);
`else
    send_bits(16'({stp, d, 1'b0}), 10 + int'(flip));
`endif
  endtask

  task automatic idle(input int n);
    rx_sync = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_perr", int'(parity_err), 0);
    nRST = 1'b1;
    idle(5);

    // 0xA5 with consumer always ready
    clr();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(8);
    check("a5_rise", n_rise, 1);
    check("a5_data", rise_data, 'hA5);
    check("a5_lat", int'((rise_t - t_start - HALF) / PER), LAT);
    check("a5_high", n_high, 1);
    check("a5_err", n_ferr + n_ovr + n_perr, 0);

    // 3-cycle low glitch
    clr();
    @(negedge CLK);
    rx_sync = 1'b0;
    repeat (3) @(negedge CLK);
    idle(40);
    check("gl_rise", n_rise, 0);
    check("gl_err", n_ferr + n_ovr + n_perr, 0);

    // bad stop bit, then line held low 40 bit-times
    clr();
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_sync = 1'b0;
    repeat (40 * CPB) @(negedge CLK);
    idle(32);
    check("fe_ferr", n_ferr, 1);
    check("fe_rise", n_rise, 0);
    check("fe_other", n_ovr + n_perr, 0);
    clr();
    send_frame(8'h11, 1'b1, 1'b0);
    idle(8);
    check("fe_next_rise", n_rise, 1);
    check("fe_next_data", rise_data, 'h11);

    // back-to-back with consumer stalled
    clr();
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    idle(8);
    check("ov_valid", int'(rx_valid), 1);
    check("ov_data", int'(rx_data), 'h01);
    check("ov_cnt", n_ovr, 1);
    check("ov_ferr", n_ferr, 0);
    rx_ready = 1'b1;
    @(negedge CLK);
    rx_ready = 1'b0;
    check("ov_drain", int'(rx_valid), 0);

    // handshake in exactly the delivery cycle
    clr();
    send_frame(8'h01, 1'b1, 1'b0);
    check("hs_pre", int'(rx_valid), 1);
    fork
      send_frame(8'h02, 1'b1, 1'b0);
      begin
        repeat (LAT + 1) @(negedge CLK);
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    check("hs_ovr", n_ovr, 0);
    check("hs_valid", int'(rx_valid), 1);
    check("hs_data", int'(rx_data), 'h02);

    // reset in the middle of 0xFF, byte 0x02 still held
    clr();
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (60) @(negedge CLK);
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        check("mr_valid", int'(rx_valid), 0);
        check("mr_data", int'(rx_data), 0);
        check("mr_ferr", int'(frame_err), 0);
        nRST = 1'b1;
      end
    join
    idle(20);
    check("mr_rise", n_rise, 0);
    check("mr_err", n_ferr + n_ovr + n_perr, 0);
    clr();
    rx_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(8);
    check("mr_5a_rise", n_rise, 1);
    check("mr_5a_data", rise_data, 'h5A);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; parity bit 0 is wrong
    clr();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    check("par_perr", n_perr, 1);
    check("par_rise", n_rise, 0);
    check("par_ferr", n_ferr, 0);
    clr();
    send_frame(8'h07, 1'b0, 1'b1);
    idle(8);
    check("par_stop_perr", n_perr, 1);
    check("par_stop_ferr", n_ferr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
